// File: rtl/if_stage_pkg.sv
// Shared widths and constants for the instruction-fetch stage.
// Also holds the helper that word-aligns a program counter.
package if_stage_pkg;

  localparam int INST_WIDTH = 32;
  localparam int PC_WIDTH   = 32;

  localparam logic [INST_WIDTH-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [PC_WIDTH-1:0]   PC_STEP      = 32'd4;

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return pc & ~(PC_WIDTH'(3));
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
// The master side is the fetch stage; the slave side is the core and memory around it.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                  stall_i;
  logic                  redirect_i;
  logic [PC_WIDTH-1:0]   redirect_pc_i;
  logic                  imem_req_o;
  logic [PC_WIDTH-1:0]   imem_addr_o;
  logic [INST_WIDTH-1:0] imem_rdata_i;
  logic                  id_valid_o;
  logic [INST_WIDTH-1:0] id_inst_o;
  logic [PC_WIDTH-1:0]   id_pc_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o
  );

endinterface

// File: rtl/if_stage_fetch_skid.sv
// One-entry holding register for a memory response that arrives while decode is stalled.
// Flush has priority over capture, capture over drain.
module fetch_skid
  import if_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_capture,
  input  logic                  i_drain,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [INST_WIDTH-1:0] i_inst,
  input  logic [PC_WIDTH-1:0]   i_pc,
  output logic                  o_skid_v,
  output logic [INST_WIDTH-1:0] o_skid_inst,
  output logic [PC_WIDTH-1:0]   o_skid_pc
);

  logic                  r_skid_v;
  logic [INST_WIDTH-1:0] r_skid_inst;
  logic [PC_WIDTH-1:0]   r_skid_pc;
  logic                  w_load;

  assign w_load = i_capture && i_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_v <= 1'b0;
    end else if (i_flush) begin
      r_skid_v <= 1'b0;
    end else if (w_load) begin
      r_skid_v <= 1'b1;
    end else if (i_drain) begin
      r_skid_v <= 1'b0;
    end
  end

  // Payload is qualified by r_skid_v, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_skid_inst <= i_inst;
      r_skid_pc   <= i_pc;
    end
  end

  assign o_skid_v    = r_skid_v;
  assign o_skid_inst = r_skid_inst;
  assign o_skid_pc   = r_skid_pc;

endmodule

// File: rtl/if_stage.sv
// RV32 instruction-fetch stage: PC, synchronous-imem response tracking,
// one-entry stall skid and the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  logic                  w_stall;
  logic                  w_redirect;
  logic                  w_fetch;
  logic                  w_req;

  logic [PC_WIDTH-1:0]   r_pc_p0;
  logic                  r_resp_vld_p1;
  logic [PC_WIDTH-1:0]   r_resp_pc_p1;

  logic                  w_skid_v;
  logic [INST_WIDTH-1:0] w_skid_inst;
  logic [PC_WIDTH-1:0]   w_skid_pc;

  logic                  w_ld_vld;
  logic [INST_WIDTH-1:0] w_ld_inst;
  logic [PC_WIDTH-1:0]   w_ld_pc;

  logic                  r_id_vld_p2;
  logic [INST_WIDTH-1:0] r_id_inst_p2;
  logic [PC_WIDTH-1:0]   r_id_pc_p2;

  assign w_stall    = bus.stall_i;
  assign w_redirect = bus.redirect_i;
  assign w_fetch    = !w_stall && !w_redirect;
  assign w_req      = rst_n && w_fetch;

  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = r_pc_p0;

  // p0 -> p1: PC advance and request tracking; redirect drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_p0       <= RESET_PC;
      r_resp_vld_p1 <= 1'b0;
    end else begin
      r_resp_vld_p1 <= w_fetch;
      if (w_redirect) begin
        r_pc_p0 <= align_pc(bus.redirect_pc_i);
      end else if (w_fetch) begin
        r_pc_p0 <= r_pc_p0 + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_resp_pc_p1 <= r_pc_p0;
  end

  fetch_skid u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_capture   (w_stall && !w_redirect),
    .i_drain     (w_fetch),
    .i_flush     (w_redirect),
    .i_valid     (r_resp_vld_p1),
    .i_inst      (bus.imem_rdata_i),
    .i_pc        (r_resp_pc_p1),
    .o_skid_v    (w_skid_v),
    .o_skid_inst (w_skid_inst),
    .o_skid_pc   (w_skid_pc)
  );

  // p1 -> p2: a held skid entry is always older than the live response
  always_comb begin
    w_ld_vld  = r_resp_vld_p1;
    w_ld_inst = r_resp_vld_p1 ? bus.imem_rdata_i : NOP_INST;
    w_ld_pc   = r_resp_pc_p1;
    if (w_skid_v) begin
      w_ld_vld  = 1'b1;
      w_ld_inst = w_skid_inst;
      w_ld_pc   = w_skid_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_vld_p2  <= 1'b0;
      r_id_inst_p2 <= NOP_INST;
      r_id_pc_p2   <= '0;
    end else if (w_redirect) begin
      r_id_vld_p2  <= 1'b0;
      r_id_inst_p2 <= NOP_INST;
    end else if (w_fetch) begin
      r_id_vld_p2  <= w_ld_vld;
      r_id_inst_p2 <= w_ld_inst;
      r_id_pc_p2   <= w_ld_pc;
    end
  end

  assign bus.id_valid_o = r_id_vld_p2;
  assign bus.id_inst_o  = r_id_inst_p2;
  assign bus.id_pc_o    = r_id_pc_p2;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a random run, checked against a
// fetch-queue model of program-order delivery.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] t;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if ifc ();

  if_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  // Synchronous memory; data is garbage in cycles after no request.
  always @(posedge clk) begin
    if (ifc.imem_req_o) ifc.imem_rdata_i <= memf(ifc.imem_addr_o);
    else                ifc.imem_rdata_i <= $urandom;
  end

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_vld;
  logic [31:0] m_inst;
  logic [31:0] m_idpc;
  logic        m_idpc_ok;

  logic        o_vld, o_req, e_vld, e_req, e_idpc_ok;
  logic [31:0] o_inst, o_pc, o_addr, e_inst, e_idpc, e_addr;

  task automatic reset_model();
    m_pc = RPC;
    m_q.delete();
    m_vld = 1'b0;
    m_inst = NOP;
    m_idpc = 32'h0;
    m_idpc_ok = 1'b1;
  endtask

  // Apply one cycle of inputs, capture DUT outputs and model expectations, advance the model.
  task automatic drive(input stim_t st);
    logic [31:0] p;
    @(negedge clk);
    ifc.stall_i = st.s;
    ifc.redirect_i = st.r;
    ifc.redirect_pc_i = st.t;
    #1;
    o_vld = ifc.id_valid_o; o_inst = ifc.id_inst_o; o_pc = ifc.id_pc_o;
    o_req = ifc.imem_req_o; o_addr = ifc.imem_addr_o;
    e_vld = m_vld; e_inst = m_inst; e_idpc = m_idpc; e_idpc_ok = m_idpc_ok;
    e_req = !st.s && !st.r; e_addr = m_pc;
    if (st.r) begin
      m_q.delete();
      m_pc = {st.t[31:2], 2'b00};
      m_vld = 1'b0;
      m_inst = NOP;
      m_idpc_ok = 1'b0;
    end else if (!st.s) begin
      if (m_q.size() > 0) begin
        p = m_q.pop_front();
        m_vld = 1'b1;
        m_inst = memf(p);
        m_idpc = p;
        m_idpc_ok = 1'b1;
      end else begin
        m_vld = 1'b0;
        m_inst = NOP;
        m_idpc_ok = 1'b0;
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  endtask

  function automatic stim_t mk(input logic s, input logic r, input logic [31:0] t);
    stim_t x;
    x.s = s; x.r = r; x.t = t;
    return x;
  endfunction

  task automatic test_reset();
    ifc.stall_i = 1'b0;
    ifc.redirect_i = 1'b0;
    ifc.redirect_pc_i = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({ifc.id_valid_o, ifc.id_inst_o, ifc.id_pc_o, ifc.imem_req_o, ifc.imem_addr_o} !==
        {1'b0, NOP, 32'h0, 1'b0, RPC}) begin
      n_err++;
      $display("FAIL reset_state actual v=%b inst=%h pc=%h req=%b addr=%h required v=0 inst=%h pc=0 req=0 addr=%h",
               ifc.id_valid_o, ifc.id_inst_o, ifc.id_pc_o, ifc.imem_req_o, ifc.imem_addr_o, NOP, RPC);
    end
    ifc.stall_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 12; i++) begin
      drive(mk(1'b0, 1'b0, 32'h0));
      n_vec++;
      if ({o_vld, o_inst} !== {e_vld, e_inst} || (e_idpc_ok && o_pc !== e_idpc) ||
          {o_req, o_addr} !== {e_req, e_addr}) begin
        n_err++;
        $display("FAIL stream[%0d] actual v=%b inst=%h pc=%h req=%b addr=%h required v=%b inst=%h pc=%h req=%b addr=%h",
                 i, o_vld, o_inst, o_pc, o_req, o_addr, e_vld, e_inst, e_idpc, e_req, e_addr);
      end
      if (i >= 2) begin
        n_vec++;
        if ({o_vld, o_pc, o_inst} !== {1'b1, 32'(4 * (i - 2)), 32'(32'h100 + i - 2)}) begin
          n_err++;
          $display("FAIL stream_seq[%0d] actual v=%b pc=%h inst=%h required v=1 pc=%h inst=%h",
                   i, o_vld, o_pc, o_inst, 32'(4 * (i - 2)), 32'(32'h100 + i - 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    stim_t sq[$];
    logic [31:0] held;
    sq = '{mk(0, 1, 32'h10), mk(0, 0, 0), mk(1, 0, 0), mk(1, 0, 0), mk(1, 0, 0),
           mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0)};
    held = 32'h0;
    foreach (sq[k]) begin
      drive(sq[k]);
      n_vec++;
      if ({o_vld, o_inst} !== {e_vld, e_inst} || (e_idpc_ok && o_pc !== e_idpc) ||
          {o_req, o_addr} !== {e_req, e_addr}) begin
        n_err++;
        $display("FAIL stall[%0d] actual v=%b inst=%h pc=%h req=%b addr=%h required v=%b inst=%h pc=%h req=%b addr=%h",
                 k, o_vld, o_inst, o_pc, o_req, o_addr, e_vld, e_inst, e_idpc, e_req, e_addr);
      end
      if (k == 2) held = o_inst;
      if (k >= 3 && k <= 5) begin
        n_vec++;
        if (o_inst !== held || o_req !== (k == 5)) begin
          n_err++;
          $display("FAIL stall_hold[%0d] actual inst=%h req=%b required inst=%h req=%b",
                   k, o_inst, o_req, held, (k == 5));
        end
      end
      if (k == 6 || k == 7) begin
        n_vec++;
        if ({o_vld, o_pc, o_inst} !== {1'b1, (k == 6) ? 32'h10 : 32'h14, (k == 6) ? 32'h104 : 32'h105}) begin
          n_err++;
          $display("FAIL stall_release[%0d] actual v=%b pc=%h inst=%h required v=1 pc=%h", k, o_vld, o_pc, o_inst,
                   (k == 6) ? 32'h10 : 32'h14);
        end
      end
    end
  endtask

  task automatic test_redirect();
    stim_t sq[$];
    logic seen;
    sq = '{mk(0, 1, 32'h20), mk(0, 0, 0), mk(0, 0, 0), mk(0, 1, 32'h200),
           mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0)};
    seen = 1'b0;
    foreach (sq[k]) begin
      drive(sq[k]);
      n_vec++;
      if ({o_vld, o_inst} !== {e_vld, e_inst} || (e_idpc_ok && o_pc !== e_idpc) ||
          {o_req, o_addr} !== {e_req, e_addr}) begin
        n_err++;
        $display("FAIL redirect[%0d] actual v=%b inst=%h pc=%h req=%b addr=%h required v=%b inst=%h pc=%h req=%b addr=%h",
                 k, o_vld, o_inst, o_pc, o_req, o_addr, e_vld, e_inst, e_idpc, e_req, e_addr);
      end
      if (k == 4) begin
        n_vec++;
        if ({o_vld, o_inst, o_req, o_addr} !== {1'b0, NOP, 1'b1, 32'h200}) begin
          n_err++;
          $display("FAIL redirect_bubble actual v=%b inst=%h req=%b addr=%h required v=0 inst=%h req=1 addr=200",
                   o_vld, o_inst, o_req, o_addr, NOP);
        end
      end
      if (k >= 4 && o_vld && !seen) begin
        seen = 1'b1;
        n_vec++;
        if (o_pc !== 32'h200) begin
          n_err++;
          $display("FAIL redirect_target actual pc=%h required pc=200", o_pc);
        end
      end
      if (k >= 4 && o_vld && o_pc === 32'h24) begin
        n_err++;
        $display("FAIL redirect_flushed actual pc=24 delivered required never");
      end
    end
  endtask

  task automatic test_redirect_stall();
    stim_t sq[$];
    sq = '{mk(0, 0, 0), mk(0, 0, 0), mk(1, 0, 0), mk(1, 0, 0), mk(1, 1, 32'h103),
           mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0)};
    foreach (sq[k]) begin
      drive(sq[k]);
      n_vec++;
      if ({o_vld, o_inst} !== {e_vld, e_inst} || (e_idpc_ok && o_pc !== e_idpc) ||
          {o_req, o_addr} !== {e_req, e_addr}) begin
        n_err++;
        $display("FAIL redir_stall[%0d] actual v=%b inst=%h pc=%h req=%b addr=%h required v=%b inst=%h pc=%h req=%b addr=%h",
                 k, o_vld, o_inst, o_pc, o_req, o_addr, e_vld, e_inst, e_idpc, e_req, e_addr);
      end
      if (k == 5) begin
        n_vec++;
        if ({o_req, o_addr} !== {1'b1, 32'h100}) begin
          n_err++;
          $display("FAIL redir_stall_addr actual req=%b addr=%h required req=1 addr=100", o_req, o_addr);
        end
      end
      if (k == 7) begin
        n_vec++;
        if ({o_vld, o_pc} !== {1'b1, 32'h100}) begin
          n_err++;
          $display("FAIL redir_stall_first actual v=%b pc=%h required v=1 pc=100", o_vld, o_pc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want[3];
    int n;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    n = 0;
    drive(mk(0, 1, 32'hFFFF_FFF8));
    for (int k = 0; k < 6; k++) begin
      drive(mk(0, 0, 0));
      n_vec++;
      if ({o_vld, o_inst} !== {e_vld, e_inst} || (e_idpc_ok && o_pc !== e_idpc) ||
          {o_req, o_addr} !== {e_req, e_addr}) begin
        n_err++;
        $display("FAIL wrap[%0d] actual v=%b inst=%h pc=%h req=%b addr=%h required v=%b inst=%h pc=%h req=%b addr=%h",
                 k, o_vld, o_inst, o_pc, o_req, o_addr, e_vld, e_inst, e_idpc, e_req, e_addr);
      end
      if (o_vld && n < 3) begin
        n_vec++;
        if (o_pc !== want[n]) begin
          n_err++;
          $display("FAIL wrap_seq[%0d] actual pc=%h required pc=%h", n, o_pc, want[n]);
        end
        n++;
      end
    end
    n_vec++;
    if (n != 3) begin
      n_err++;
      $display("FAIL wrap_count actual %0d required 3", n);
    end
  endtask

  task automatic test_reset_mid();
    drive(mk(0, 0, 0));
    drive(mk(1, 0, 0));
    drive(mk(1, 0, 0));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ifc.id_valid_o, ifc.id_inst_o, ifc.id_pc_o, ifc.imem_req_o, ifc.imem_addr_o} !==
        {1'b0, NOP, 32'h0, 1'b0, RPC}) begin
      n_err++;
      $display("FAIL reset_async actual v=%b inst=%h pc=%h req=%b addr=%h required v=0 inst=%h pc=0 req=0 addr=%h",
               ifc.id_valid_o, ifc.id_inst_o, ifc.id_pc_o, ifc.imem_req_o, ifc.imem_addr_o, NOP, RPC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int k = 0; k < 6; k++) begin
      drive(mk(0, 0, 0));
      n_vec++;
      if ({o_vld, o_inst} !== {e_vld, e_inst} || (e_idpc_ok && o_pc !== e_idpc) ||
          {o_req, o_addr} !== {e_req, e_addr}) begin
        n_err++;
        $display("FAIL reset_restart[%0d] actual v=%b inst=%h pc=%h req=%b addr=%h required v=%b inst=%h pc=%h req=%b addr=%h",
                 k, o_vld, o_inst, o_pc, o_req, o_addr, e_vld, e_inst, e_idpc, e_req, e_addr);
      end
    end
  endtask

  task automatic test_random();
    stim_t st;
    for (int k = 0; k < 400; k++) begin
      st.s = ($urandom_range(0, 9) < 3);
      st.r = ($urandom_range(0, 11) == 0);
      st.t = ($urandom_range(0, 1) == 0) ? $urandom : 32'(($urandom_range(0, 63)) * 4 + $urandom_range(0, 3));
      drive(st);
      n_vec++;
      if ({o_vld, o_inst} !== {e_vld, e_inst} || (e_idpc_ok && o_pc !== e_idpc) ||
          {o_req, o_addr} !== {e_req, e_addr}) begin
        n_err++;
        $display("FAIL random[%0d] actual v=%b inst=%h pc=%h req=%b addr=%h required v=%b inst=%h pc=%h req=%b addr=%h",
                 k, o_vld, o_inst, o_pc, o_req, o_addr, e_vld, e_inst, e_idpc, e_req, e_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
